// File: rtl/clk_pkg.sv
// Shared constants for the clock divider: default input frequency and counter width.
// Latency: n/a (package only).
// Backpressure: n/a.
package clk_pkg;

  localparam int unsigned CLK_IN_FREQ_DEFAULT = 50_000_000;
  localparam int          CNT_W               = 32;

  // Half-period in input cycles, integer division, never below one cycle.
  function automatic int unsigned half_cycles(input int unsigned fin, input int unsigned fout);
    int unsigned h;
    if (fout == 0) return 1;
    h = fin / (2 * fout);
    return (h < 1) ? 1 : h;
  endfunction

endpackage

// File: rtl/clk_gen_counter.sv
// Enable-gated modulo-HALF counter; wrap strobes in the enabled cycle where cnt==HALF-1.
// Latency: wrap is combinational from cnt/clken; cnt updates on the next clkin edge.
// Backpressure: clken=0 freezes cnt and suppresses wrap.
module clk_gen_counter
  import clk_pkg::*;
#(
  parameter int unsigned HALF = 1
) (
  input  logic clkin,
  input  logic rst,
  input  logic clken,
  output logic wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt;

  assign wrap = clken && (cnt == LAST);

  // Count enabled cycles, returning to zero on the half-period boundary.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else if (clken) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clk_gen.sv
// Divides clkin down to a 50% duty clkout of period 2*HALF cycles; optional rise tick (CLK_GEN_TICK_EN).
// Latency: first clkout rise HALF enabled cycles after reset release; clkout/tick are registered.
// Backpressure: clken=0 freezes the count and clkout with no lost or extra edge.
module clk_gen
  import clk_pkg::*;
#(
  parameter int unsigned clk_freq    = 1000,
  parameter int unsigned CLK_IN_FREQ = CLK_IN_FREQ_DEFAULT
) (
  input  logic clkin,
  input  logic rst,
  input  logic clken,
  output logic clkout
`ifdef CLK_GEN_TICK_EN
  ,
  output logic clkout_tick
`endif
);

  localparam int unsigned HALF = half_cycles(CLK_IN_FREQ, clk_freq);

  // A zero or above-input output frequency has no meaningful divider.
  if (clk_freq == 0 || clk_freq > CLK_IN_FREQ) begin : g_bad_freq
    $error("clk_gen: illegal clk_freq=%0d for CLK_IN_FREQ=%0d", clk_freq, CLK_IN_FREQ);
  end

  logic wrap;

  clk_gen_counter #(
    .HALF (HALF)
  ) u_counter (
    .clkin (clkin),
    .rst   (rst),
    .clken (clken),
    .wrap  (wrap)
  );

  // clkout comes straight from this flop so it cannot glitch.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      clkout <= 1'b0;
    end else if (wrap) begin
      clkout <= ~clkout;
    end
  end

`ifdef CLK_GEN_TICK_EN
  // Tick is high exactly in the cycle clkout becomes 1.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      clkout_tick <= 1'b0;
    end else begin
      clkout_tick <= wrap && !clkout;
    end
  end
`endif

endmodule

// File: tb/tb_clk_gen.sv
// Scoreboard bench for clk_gen: expected clkout edges and timed probes are queued up front,
// a negedge monitor pops edges as the DUT produces them and evaluates probes at their cycle.
module tb_clk_gen;

  typedef struct {
    logic   val;
    longint at;
  } edge_t;

  typedef struct {
    longint at;
    int     id;
    longint exp;
    string  name;
  } probe_t;

  localparam longint A     = 5;          // reset release cycle
  localparam longint P     = A + 15300;  // async reset assertion cycle (cnt=1800, high phase)
  localparam longint RR    = P + 4;      // second release
  localparam longint T_END = RR + 5010;
  localparam longint LIMIT = T_END + 200;

  logic clkin = 1'b0;
  logic rst_a, rst_bc, clken_a, clken_bc;
  logic clkout_a, clkout_b, clkout_c;
`ifdef CLK_GEN_TICK_EN
  logic tick_a, tick_b, tick_c;
`endif

  longint cyc = 0;
  int     checks = 0;
  int     fails = 0;
  bit     done = 1'b0;
  logic   prev_a = 1'b0;
  edge_t  edge_q[$];
  probe_t probe_q[$];
  edge_t  e;
  longint got;

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  clk_gen #(.clk_freq(10000), .CLK_IN_FREQ(50_000_000)) u_dut_a (
    .clkin(clkin), .rst(rst_a), .clken(clken_a), .clkout(clkout_a)
`ifdef CLK_GEN_TICK_EN
    , .clkout_tick(tick_a)
`endif
  );

  clk_gen #(.clk_freq(25_000_000), .CLK_IN_FREQ(50_000_000)) u_dut_b (
    .clkin(clkin), .rst(rst_bc), .clken(clken_bc), .clkout(clkout_b)
`ifdef CLK_GEN_TICK_EN
    , .clkout_tick(tick_b)
`endif
  );

  clk_gen #(.clk_freq(30_000_000), .CLK_IN_FREQ(50_000_000)) u_dut_c (
    .clkin(clkin), .rst(rst_bc), .clken(clken_bc), .clkout(clkout_c)
`ifdef CLK_GEN_TICK_EN
    , .clkout_tick(tick_c)
`endif
  );

  function automatic longint probe_val(input int id);
    case (id)
      0: return longint'(u_dut_a.u_counter.cnt);
      1: return longint'(clkout_a);
      2: return longint'(clkout_b);
      3: return longint'(clkout_c);
`ifdef CLK_GEN_TICK_EN
      4: return longint'(tick_a);
      5: return longint'(tick_b);
      6: return longint'(tick_c);
`endif
      default: return -1;
    endcase
  endfunction

  // Monitor: match every clkout_a change to the next queued edge, then run due probes.
  always @(negedge clkin) begin
    if (clkout_a !== prev_a) begin
      checks++;
      if (edge_q.size() == 0) begin
        fails++;
        $display("FAIL edge_a_unexpected: clkout=%0b at cyc %0d, required no edge", clkout_a, cyc);
      end else begin
        e = edge_q.pop_front();
        if (e.val !== clkout_a || e.at != cyc) begin
          fails++;
          $display("FAIL edge_a: got %0b at cyc %0d, required %0b at cyc %0d",
                   clkout_a, cyc, e.val, e.at);
        end
      end
      prev_a = clkout_a;
    end
    for (int i = probe_q.size() - 1; i >= 0; i--) begin
      if (probe_q[i].at == cyc) begin
        checks++;
        if (probe_q[i].id == 99) begin
          if (edge_q.size() != 0) begin
            fails++;
            $display("FAIL edges_missing: %0d expected edges never seen, required 0", edge_q.size());
          end
          done = 1'b1;
        end else begin
          got = probe_val(probe_q[i].id);
          if (got != probe_q[i].exp) begin
            fails++;
            $display("FAIL %s: got %0d at cyc %0d, required %0d",
                     probe_q[i].name, got, cyc, probe_q[i].exp);
          end
        end
        probe_q.delete(i);
      end
    end
  end

  task automatic add_edge(input logic v, input longint at);
    edge_q.push_back('{val: v, at: at});
  endtask

  task automatic add_probe(input longint at, input int id, input longint exp, input string name);
    probe_q.push_back('{at: at, id: id, exp: exp, name: name});
  endtask

  task automatic wait_neg(input longint t);
    while (cyc < t) @(negedge clkin);
  endtask

  initial begin
    rst_a = 1'b1; rst_bc = 1'b1; clken_a = 1'b1; clken_bc = 1'b1;

    // Divide-by-5000 timeline: rise at +2500, 50% duty, pause, async reset, restart.
    add_edge(1'b1, A + 2500);
    add_edge(1'b0, A + 5000);
    add_edge(1'b1, A + 7500);
    add_edge(1'b0, A + 11000);   // 1000-cycle pause at cnt=1200 delays this edge
    add_edge(1'b1, A + 13500);
    add_edge(1'b0, P);           // async reset, before any further clkin edge
    add_edge(1'b1, RR + 2500);
    add_edge(1'b0, RR + 5000);

    add_probe(2, 0, 0, "reset_cnt_a");
    add_probe(2, 1, 0, "reset_clkout_a");
    add_probe(2, 2, 0, "reset_clkout_b");
    add_probe(2, 3, 0, "reset_clkout_c");
    add_probe(A + 8700, 0, 1200, "pause_start_cnt");
    add_probe(A + 9700, 0, 1200, "pause_end_cnt");
    add_probe(A + 9700, 1, 1, "pause_end_clkout");
    add_probe(P - 1, 0, 1799, "pre_reset_cnt");
    add_probe(P, 0, 0, "async_reset_cnt");
    add_probe(RR, 0, 0, "held_reset_cnt");
    add_probe(RR + 1, 0, 1, "restart_cnt");
    for (int k = 1; k <= 6; k++) begin
      add_probe(A + k, 2, k % 2, "half1_clkout_b");
      add_probe(A + k, 3, k % 2, "half_clamped_clkout_c");
    end
`ifdef CLK_GEN_TICK_EN
    add_probe(A + 2500, 4, 1, "tick_a_rise1");
    add_probe(A + 2501, 4, 0, "tick_a_after1");
    add_probe(A + 5000, 4, 0, "tick_a_fall");
    add_probe(A + 7500, 4, 1, "tick_a_rise2");
    add_probe(A + 7501, 4, 0, "tick_a_after2");
    add_probe(RR + 2500, 4, 1, "tick_a_restart");
    add_probe(A + 1, 5, 1, "tick_b_1");
    add_probe(A + 2, 5, 0, "tick_b_2");
    add_probe(A + 3, 6, 1, "tick_c_3");
`endif
    add_probe(T_END, 99, 0, "end");

    #1 rst_a = 1'b0; rst_bc = 1'b0;
    wait_neg(A);
    rst_a = 1'b1; rst_bc = 1'b1;
    wait_neg(A + 8700);
    clken_a = 1'b0;
    wait_neg(A + 9700);
    clken_a = 1'b1;
    wait_neg(P - 1);
    @(posedge clkin);
    #2 rst_a = 1'b0;
    wait_neg(RR);
    rst_a = 1'b1;
    while (!done && cyc < LIMIT) @(negedge clkin);
    if (!done) begin
      $display("FAIL timeout: monitor not done at cyc %0d, required done by %0d", cyc, LIMIT);
      $fatal(1, "timeout");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
